// File: rtl/fir_inverse.sv
// Inverse of a 4-tap FIR (h0 = 1): recovers 8-bit input samples from the
// forward filter output, one sample per cycle, 1-cycle latency.
// Any recovery outside 0..255 latches FAULT until clr or rst.
module fir_inverse #(
    parameter logic [7:0] H1 = 8'd4,
    parameter logic [7:0] H2 = 8'd11,
    parameter logic [7:0] H3 = 8'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] y_in,
    input  logic        clr,
    output logic        out_valid,
    output logic [7:0]  x_out,
    output logic        err,
    output logic [15:0] sample_cnt
);

    localparam int unsigned XW = 8;
    localparam int unsigned YW = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [XW-1:0] xh1, xh2, xh3;
    logic [XW-1:0] xh1_n, xh2_n, xh3_n;
    logic [XW-1:0] x_out_n;
    logic          out_valid_n;
    logic          err_n;
    logic [YW-1:0] sample_cnt_n;
    logic [YW-1:0] r;

    // Residual after removing the contribution of the recovered history
    always_comb begin
        r = y_in
            - (YW'(H1) * YW'(xh1))
            - (YW'(H2) * YW'(xh2))
            - (YW'(H3) * YW'(xh3));
    end

    // Next-state and next-output logic; clr overrides everything else
    always_comb begin
        state_n      = state;
        xh1_n        = xh1;
        xh2_n        = xh2;
        xh3_n        = xh3;
        x_out_n      = x_out;
        out_valid_n  = 1'b0;
        err_n        = err;
        sample_cnt_n = sample_cnt;

        if (clr) begin
            state_n      = IDLE;
            xh1_n        = '0;
            xh2_n        = '0;
            xh3_n        = '0;
            x_out_n      = '0;
            err_n        = 1'b0;
            sample_cnt_n = '0;
        end else begin
            case (state)
                IDLE, RUN: begin
                    if (in_valid) begin
                        if (r[YW-1:XW] == '0) begin
                            state_n      = RUN;
                            xh3_n        = xh2;
                            xh2_n        = xh1;
                            xh1_n        = r[XW-1:0];
                            x_out_n      = r[XW-1:0];
                            out_valid_n  = 1'b1;
                            sample_cnt_n = sample_cnt + YW'(1);
                        end else begin
                            state_n = FAULT;
                            err_n   = 1'b1;
                        end
                    end
                end
                FAULT: begin
                    err_n = 1'b1;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // State, history and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            xh1        <= '0;
            xh2        <= '0;
            xh3        <= '0;
            x_out      <= '0;
            out_valid  <= 1'b0;
            err        <= 1'b0;
            sample_cnt <= '0;
        end else begin
            state      <= state_n;
            xh1        <= xh1_n;
            xh2        <= xh2_n;
            xh3        <= xh3_n;
            x_out      <= x_out_n;
            out_valid  <= out_valid_n;
            err        <= err_n;
            sample_cnt <= sample_cnt_n;
        end
    end

endmodule

// File: tb/tb_fir_inverse.sv
// Self-checking bench for fir_inverse: directed scenarios plus a random
// stream pushed through a forward-filter model and compared sample by sample.
module tb_fir_inverse;

    localparam int H1 = 4;
    localparam int H2 = 11;
    localparam int H3 = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] y_in = '0;
    logic        clr = 1'b0;
    logic        out_valid;
    logic [7:0]  x_out;
    logic        err;
    logic [15:0] sample_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    fir_inverse #(
        .H1(8'(H1)),
        .H2(8'(H2)),
        .H3(8'(H3))
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .y_in      (y_in),
        .clr       (clr),
        .out_valid (out_valid),
        .x_out     (x_out),
        .err       (err),
        .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, then settle just after the rising edge
    task automatic cycle(input bit v, input logic [15:0] y, input bit c);
        in_valid = v;
        y_in     = y;
        clr      = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clr      = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Forward filter: y = x0 + H1*x1 + H2*x2 + H3*x3
    function automatic logic [15:0] fwd(input int x0, input int x1, input int x2, input int x3);
        return 16'(x0 + H1 * x1 + H2 * x2 + H3 * x3);
    endfunction

    task automatic test_reset();
        in_valid = 1'b1;
        y_in     = 16'd10;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({out_valid, x_out, err, sample_cnt} !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_async: got ov=%b x=%0d err=%b cnt=%0d, want all 0",
                     out_valid, x_out, err, sample_cnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || sample_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_hold: got ov=%b cnt=%0d, want 0 0", out_valid, sample_cnt);
        end
    endtask

    task automatic test_basic();
        logic [15:0] ys [4];
        logic [7:0]  xs [4];
        ys[0] = 16'd10; ys[1] = 16'd40; ys[2] = 16'd110; ys[3] = 16'd40;
        xs[0] = 8'd10;  xs[1] = 8'd0;   xs[2] = 8'd0;    xs[3] = 8'd0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, ys[i], 1'b0);
            n_tests++;
            if (out_valid !== 1'b1 || x_out !== xs[i] || err !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_%0d: got ov=%b x=%0d err=%b, want 1 %0d 0",
                         i, out_valid, x_out, err, xs[i]);
            end
        end
        cycle(1'b0, 16'd0, 1'b0);
        n_tests++;
        if (out_valid !== 1'b0 || sample_cnt !== 16'd4 || x_out !== 8'd0) begin
            n_fail++;
            $display("FAIL basic_end: got ov=%b cnt=%0d x=%0d, want 0 4 0",
                     out_valid, sample_cnt, x_out);
        end
    endtask

    task automatic test_fault();
        do_reset();
        cycle(1'b1, 16'd300, 1'b0);
        n_tests++;
        if (err !== 1'b1 || out_valid !== 1'b0 || x_out !== 8'd0) begin
            n_fail++;
            $display("FAIL fault_enter: got err=%b ov=%b x=%0d, want 1 0 0", err, out_valid, x_out);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 16'd10, 1'b0);
            n_tests++;
            if (err !== 1'b1 || out_valid !== 1'b0 || sample_cnt !== 16'd0) begin
                n_fail++;
                $display("FAIL fault_ignore_%0d: got err=%b ov=%b cnt=%0d, want 1 0 0",
                         i, err, out_valid, sample_cnt);
            end
        end
        cycle(1'b0, 16'd0, 1'b1);
        n_tests++;
        if (err !== 1'b0 || out_valid !== 1'b0 || x_out !== 8'd0) begin
            n_fail++;
            $display("FAIL fault_clr: got err=%b ov=%b x=%0d, want 0 0 0", err, out_valid, x_out);
        end
        cycle(1'b1, 16'd10, 1'b0);
        n_tests++;
        if (out_valid !== 1'b1 || x_out !== 8'd10 || sample_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL fault_recover: got ov=%b x=%0d cnt=%0d, want 1 10 1",
                     out_valid, x_out, sample_cnt);
        end
    endtask

    task automatic test_negative();
        cycle(1'b0, 16'd0, 1'b1);
        cycle(1'b1, 16'd10, 1'b0);
        cycle(1'b1, 16'd0, 1'b0);
        n_tests++;
        if (err !== 1'b1 || out_valid !== 1'b0 || x_out !== 8'd10 || sample_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL negative: got err=%b ov=%b x=%0d cnt=%0d, want 1 0 10 1",
                     err, out_valid, x_out, sample_cnt);
        end
    endtask

    task automatic test_clr_collide();
        cycle(1'b0, 16'd0, 1'b1);
        cycle(1'b1, 16'd10, 1'b0);
        cycle(1'b1, 16'd40, 1'b0);
        cycle(1'b1, 16'd110, 1'b1);
        n_tests++;
        if ({out_valid, x_out, err, sample_cnt} !== 26'd0) begin
            n_fail++;
            $display("FAIL clr_collide: got ov=%b x=%0d err=%b cnt=%0d, want all 0",
                     out_valid, x_out, err, sample_cnt);
        end
        cycle(1'b1, 16'd10, 1'b0);
        n_tests++;
        if (out_valid !== 1'b1 || x_out !== 8'd10) begin
            n_fail++;
            $display("FAIL clr_seq0: got ov=%b x=%0d, want 1 10", out_valid, x_out);
        end
        cycle(1'b1, 16'd40, 1'b0);
        n_tests++;
        if (out_valid !== 1'b1 || x_out !== 8'd0 || sample_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL clr_seq1: got ov=%b x=%0d cnt=%0d, want 1 0 2", out_valid, x_out, sample_cnt);
        end
    endtask

    task automatic test_rst_midstream();
        cycle(1'b0, 16'd0, 1'b1);
        cycle(1'b1, 16'd10, 1'b0);
        in_valid = 1'b1;
        y_in     = 16'd40;
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || x_out !== 8'd0 || sample_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_mid_async: got ov=%b x=%0d cnt=%0d, want 0 0 0",
                     out_valid, x_out, sample_cnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        cycle(1'b1, 16'd10, 1'b0);
        n_tests++;
        if (out_valid !== 1'b1 || x_out !== 8'd10 || err !== 1'b0 || sample_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL rst_mid_first: got ov=%b x=%0d err=%b cnt=%0d, want 1 10 0 1",
                     out_valid, x_out, err, sample_cnt);
        end
    endtask

    task automatic test_random();
        int p1 = 0, p2 = 0, p3 = 0;
        int x;
        int last = 0;
        int bad = 0;
        cycle(1'b0, 16'd0, 1'b1);
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
                    cycle(1'b0, 16'($urandom), 1'b0);
                    n_tests++;
                    if (out_valid !== 1'b0 || x_out !== 8'(last)) begin
                        n_fail++;
                        bad++;
                        if (bad < 10)
                            $display("FAIL rand_gap_%0d: got ov=%b x=%0d, want 0 %0d",
                                     i, out_valid, x_out, last);
                    end
                end
            end
            x = int'($urandom_range(0, 255));
            cycle(1'b1, fwd(x, p1, p2, p3), 1'b0);
            n_tests++;
            if (out_valid !== 1'b1 || x_out !== 8'(x) || err !== 1'b0) begin
                n_fail++;
                bad++;
                if (bad < 10)
                    $display("FAIL rand_sample_%0d: got ov=%b x=%0d err=%b, want 1 %0d 0",
                             i, out_valid, x_out, err, x);
            end
            p3 = p2;
            p2 = p1;
            p1 = x;
            last = x;
        end
        n_tests++;
        if (sample_cnt !== 16'd1200 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_count: got cnt=%0d err=%b, want 1200 0", sample_cnt, err);
        end
    endtask

    task automatic test_wrap();
        cycle(1'b0, 16'd0, 1'b1);
        for (int i = 0; i < 65535; i++) cycle(1'b1, 16'd0, 1'b0);
        n_tests++;
        if (sample_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL wrap_preload: got cnt=%h, want ffff", sample_cnt);
        end
        cycle(1'b1, 16'd7, 1'b0);
        n_tests++;
        if (sample_cnt !== 16'h0000 || out_valid !== 1'b1 || err !== 1'b0 || x_out !== 8'd7) begin
            n_fail++;
            $display("FAIL wrap: got cnt=%h ov=%b err=%b x=%0d, want 0000 1 0 7",
                     sample_cnt, out_valid, err, x_out);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_fault();
        test_negative();
        test_clr_collide();
        test_rst_midstream();
        test_random();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
